// File: rtl/pl_pkg.sv
// Shared types and constants for the program loader, its bench and the processor top.
package pl_pkg;
    localparam int          LEN_W         = 16;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0020;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } pl_state_e;
endpackage

// File: rtl/program_load_ctrl.sv
// Streams instruction words into instruction memory and owns the processor reset,
// releasing it a fixed number of cycles after the last write.
module program_load_ctrl
    import pl_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
    parameter int                MAX_WORDS   = 1024,
    parameter int                HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fm_write_enable,
    output logic [ADDR_W-1:0] fm_write_addr,
    output logic [DATA_W-1:0] fm_write_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  word_count
);

    pl_state_e         r_state;
    pl_state_e         w_next;
    logic              w_hs;
    logic              w_last;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_hold_load;
    logic              w_abort_act;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_wc;
    logic [LEN_W-1:0]  r_len;
    logic [3:0]        r_hold_cnt;
    logic              r_error;
    logic              r_cpu_reset;
    logic              r_done;

    assign w_hs        = in_valid && (r_state == LOAD);
    assign w_last      = ((r_wc + 16'd1) == r_len);
    assign w_abort_act = abort && ((r_state == LOAD) || (r_state == HOLD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_hold_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if ((load_len != '0) && (32'(load_len) <= MAX_WORDS)) begin
                        w_start_ok = 1'b1;
                        w_next     = LOAD;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                // A final word arriving with abort is still written, but abort wins the state.
                if (abort) begin
                    w_next = IDLE;
                end else if (w_hs && w_last) begin
                    w_next      = HOLD;
                    w_hold_load = 1'b1;
                end
            end
            HOLD: begin
                if (abort)                 w_next = IDLE;
                else if (r_hold_cnt <= 4'd1) w_next = RELEASE;
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_data      <= '0;
            r_wc        <= '0;
            r_len       <= '0;
            r_hold_cnt  <= '0;
            r_error     <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_we <= w_hs;
            if (w_hs) begin
                r_addr <= BASE_ADDR + ADDR_W'(r_wc);
                r_data <= in_data;
            end

            if (w_start_ok)  r_wc <= '0;
            else if (w_hs)   r_wc <= r_wc + 16'd1;
            if (w_start_ok)  r_len <= load_len;

            if (w_hold_load)                               r_hold_cnt <= 4'(HOLD_CYCLES);
            else if ((r_state == HOLD) && (r_hold_cnt != '0)) r_hold_cnt <= r_hold_cnt - 4'd1;

            if (w_start_ok)                      r_error <= 1'b0;
            else if (w_start_bad || w_abort_act) r_error <= 1'b1;

            // Processor reset drops only for a completed load; aborts leave it asserted.
            if (w_start_ok)              r_cpu_reset <= 1'b1;
            else if (w_next == RELEASE)  r_cpu_reset <= 1'b0;

            r_done <= (w_next == RELEASE);
        end
    end

    assign in_ready        = (r_state == LOAD);
    assign busy            = (r_state == LOAD) || (r_state == HOLD);
    assign fm_write_enable = r_we;
    assign fm_write_addr   = r_addr;
    assign fm_write_data   = r_data;
    assign cpu_reset       = r_cpu_reset;
    assign done            = r_done;
    assign error           = r_error;
    assign word_count      = r_wc;

endmodule

// File: tb/tb_program_load_ctrl.sv
// Directed self-checking bench for program_load_ctrl.
module tb_program_load_ctrl;
    import pl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] load_len = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        fm_write_enable;
    logic [31:0] fm_write_addr;
    logic [15:0] fm_write_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    program_load_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fm_write_enable(fm_write_enable), .fm_write_addr(fm_write_addr),
        .fm_write_data(fm_write_data), .cpu_reset(cpu_reset), .busy(busy),
        .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (fm_write_enable !== 1'b0 || fm_write_addr !== 32'h20 || fm_write_data !== 16'h0 ||
            cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            word_count !== 16'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_values we=%b addr=%h data=%h cpu_rst=%b busy=%b done=%b err=%b wc=%0d rdy=%b (want 0 20 0 1 0 0 0 0 0)",
                     fm_write_enable, fm_write_addr, fm_write_data, cpu_reset, busy, done, error, word_count, in_ready);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_normal_load();
        logic [15:0] words [3];
        words[0] = 16'h89BF; words[1] = 16'h44BF; words[2] = 16'h68BF;
        start = 1'b1; load_len = 16'd3;
        tick();
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL normal_enter_load rdy=%b busy=%b cpu_rst=%b want 1 1 1", in_ready, busy, cpu_reset);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            tick();
            checks++;
            if (fm_write_enable !== 1'b1 || fm_write_addr !== 32'h20 + 32'(i) || fm_write_data !== words[i] ||
                word_count !== 16'(i + 1)) begin
                failures++;
                $display("FAIL normal_write%0d we=%b addr=%h data=%h wc=%0d want 1 %h %h %0d",
                         i, fm_write_enable, fm_write_addr, fm_write_data, word_count, 32'h20 + 32'(i), words[i], i + 1);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL normal_hold_entry rdy=%b cpu_rst=%b busy=%b want 0 1 1", in_ready, cpu_reset, busy);
        end
        tick();
        checks++;
        if (fm_write_enable !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL normal_hold2 we=%b cpu_rst=%b done=%b want 0 1 0", fm_write_enable, cpu_reset, done);
        end
        tick();
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL normal_release cpu_rst=%b done=%b busy=%b want 0 1 0", cpu_reset, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || cpu_reset !== 1'b0 || word_count !== 16'd3 || error !== 1'b0) begin
            failures++;
            $display("FAIL normal_idle_after done=%b cpu_rst=%b wc=%0d err=%b want 0 0 3 0", done, cpu_reset, word_count, error);
        end
    endtask

    task automatic test_gapped_stream();
        int writes = 0;
        start = 1'b1; load_len = 16'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111;
        tick();
        checks++;
        if (fm_write_enable !== 1'b1 || fm_write_addr !== 32'h20 || fm_write_data !== 16'h1111) begin
            failures++;
            $display("FAIL gap_write0 we=%b addr=%h data=%h want 1 20 1111", fm_write_enable, fm_write_addr, fm_write_data);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (fm_write_enable === 1'b1) writes++;
        end
        checks++;
        if (writes !== 0 || word_count !== 16'd1) begin
            failures++;
            $display("FAIL gap_no_write writes=%0d wc=%0d want 0 1", writes, word_count);
        end
        in_valid = 1'b1; in_data = 16'h2222;
        tick();
        in_data = 16'h3333;
        checks++;
        if (fm_write_enable !== 1'b1 || fm_write_addr !== 32'h21 || fm_write_data !== 16'h2222) begin
            failures++;
            $display("FAIL gap_write1 we=%b addr=%h data=%h want 1 21 2222", fm_write_enable, fm_write_addr, fm_write_data);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (fm_write_enable !== 1'b1 || fm_write_addr !== 32'h22 || fm_write_data !== 16'h3333) begin
            failures++;
            $display("FAIL gap_write2 we=%b addr=%h data=%h want 1 22 3333", fm_write_enable, fm_write_addr, fm_write_data);
        end
        tick(); tick();
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL gap_release done=%b cpu_rst=%b want 1 0", done, cpu_reset);
        end
        tick();
    endtask

    task automatic test_illegal_len();
        logic [15:0] lens [2];
        lens[0] = 16'd0; lens[1] = 16'd1025;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; load_len = lens[i];
            tick();
            start = 1'b0;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || fm_write_enable !== 1'b0 ||
                cpu_reset !== 1'b0) begin
                failures++;
                $display("FAIL illegal_len%0d err=%b busy=%b rdy=%b we=%b cpu_rst=%b want 1 0 0 0 0",
                         lens[i], error, busy, in_ready, fm_write_enable, cpu_reset);
            end
        end
    endtask

    task automatic test_abort();
        int writes = 0;
        start = 1'b1; load_len = 16'd4;
        tick();
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL abort_start_clears err=%b cpu_rst=%b want 0 1", error, cpu_reset);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 16'(16'hA000 + i);
            tick();
            if (fm_write_enable === 1'b1) writes++;
        end
        in_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        if (fm_write_enable === 1'b1) writes++;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fm_write_enable === 1'b1) writes++;
        end
        in_valid = 1'b0;
        checks++;
        if (writes !== 2 || error !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_result writes=%0d err=%b cpu_rst=%b busy=%b rdy=%b want 2 1 1 0 0",
                     writes, error, cpu_reset, busy, in_ready);
        end
        // Restart and finish a one-word load so the processor is released again.
        start = 1'b1; load_len = 16'd1;
        tick();
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart err=%b busy=%b want 0 1", error, busy);
        end
        in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart_done done=%b cpu_rst=%b want 1 0", done, cpu_reset);
        end
        tick();
    endtask

    task automatic test_reload();
        start = 1'b1; load_len = 16'd1;
        tick();
        start = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL reload_cpu_reset got=%b want 1", cpu_reset);
        end
        in_valid = 1'b1; in_data = 16'h5A5A;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fm_write_enable !== 1'b1 || fm_write_addr !== 32'h20 || fm_write_data !== 16'h5A5A || word_count !== 16'd1) begin
            failures++;
            $display("FAIL reload_write we=%b addr=%h data=%h wc=%0d want 1 20 5a5a 1",
                     fm_write_enable, fm_write_addr, fm_write_data, word_count);
        end
        tick();
        checks++;
        if (done !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL reload_hold done=%b cpu_rst=%b want 0 1", done, cpu_reset);
        end
        tick();
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL reload_done done=%b cpu_rst=%b want 1 0", done, cpu_reset);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1; load_len = 16'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'hC0DE;
        tick();
        in_data = 16'hC0DF;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (fm_write_enable !== 1'b0 || fm_write_addr !== 32'h20 || fm_write_data !== 16'h0 ||
            cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            word_count !== 16'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_load we=%b addr=%h data=%h cpu_rst=%b busy=%b done=%b err=%b wc=%0d rdy=%b",
                     fm_write_enable, fm_write_addr, fm_write_data, cpu_reset, busy, done, error, word_count, in_ready);
        end
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || cpu_reset !== 1'b1 || fm_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after busy=%b cpu_rst=%b we=%b want 0 1 0", busy, cpu_reset, fm_write_enable);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_gapped_stream();
        test_illegal_len();
        test_abort();
        test_reload();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
